// File: rtl/trace_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trace_buffer_pkg
// Description : Shared types and sizing helpers for the trigger trace buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package trace_buffer_pkg;

    localparam int C_DEF_N          = 8;
    localparam int C_DEF_DATA_WIDTH = 32;
    localparam int C_DEF_TB_SIZE    = 64;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        POST   = 3'd2,
        FROZEN = 3'd3,
        DUMP   = 3'd4
    } tb_state_t;

    function automatic int calc_aw(input int size);
        return $clog2(size);
    endfunction

    function automatic int calc_mem_width(input int n, input int dw);
        return n * dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trigger_trace_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : trigger_trace_buffer_if
// Description : Readout handshake bundle (vector, valid/ready, last).
// Revision    : 1.0 - initial release
// ============================================================================
interface trigger_trace_buffer_if #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] vector_out [N];
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (output vector_out, output out_valid, output out_last, input out_ready);
    modport slave  (input vector_out, input out_valid, input out_last, output out_ready);
endinterface
`default_nettype wire

// File: rtl/ram_dual_port.sv
`default_nettype none
// ============================================================================
// Module      : ram_dual_port
// Description : Simple dual-port RAM, write on port A, registered read on B.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_dual_port #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             i_a_we,
    input  wire logic [AW-1:0]    i_a_addr,
    input  wire logic [WIDTH-1:0] i_a_wdata,
    input  wire logic             i_b_re,
    input  wire logic [AW-1:0]    i_b_addr,
    output logic      [WIDTH-1:0] o_b_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_a_we) begin
            r_mem[i_a_addr] <= i_a_wdata;
        end
        if (i_b_re) begin
            o_b_rdata <= r_mem[i_b_addr];
        end
    end
endmodule
`default_nettype wire

// File: rtl/trigger_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : trigger_trace_buffer
// Description : Circular trace buffer with trigger/freeze and oldest-first dump.
// Revision    : 1.0 - initial release
// ============================================================================
module trigger_trace_buffer
    import trace_buffer_pkg::*;
#(
    parameter  int N          = C_DEF_N,
    parameter  int DATA_WIDTH = C_DEF_DATA_WIDTH,
    parameter  int TB_SIZE    = C_DEF_TB_SIZE,
    localparam int AW         = calc_aw(TB_SIZE),
    localparam int MEM_WIDTH  = calc_mem_width(N, DATA_WIDTH)
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  tracing,
    input  wire logic                  valid_in,
    input  wire logic [DATA_WIDTH-1:0] vector_in [N],
    input  wire logic                  trigger_in,
    input  wire logic [AW:0]           post_trig,
    input  wire logic                  dump_start,
    trigger_trace_buffer_if.master     dump,
    output logic      [AW:0]           fill_count,
    output logic                       wrapped,
    output logic                       frozen
);
    localparam logic [AW:0]   C_FULL  = (AW+1)'(TB_SIZE);
    localparam logic [AW:0]   C_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] C_PINC  = AW'(1);

    tb_state_t r_state, w_state_nxt;

    logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [AW:0]          r_fill, r_post_cnt, r_rd_left;
    logic                 r_wrapped, r_frozen;
    logic                 w_wr, w_rd_issue, w_pop;
    logic                 r_rd_vld, r_rd_last;
    logic [1:0]           w_occ;
    logic [MEM_WIDTH-1:0] w_wdata, w_rdata, r_out_data, r_skid_data;
    logic                 r_out_valid, r_out_last, r_skid_vld, r_skid_last;

    // Lane 0 sits in the most significant slice of a RAM word.
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        assign w_wdata[MEM_WIDTH-1-gi*DATA_WIDTH -: DATA_WIDTH] = vector_in[gi];
        assign dump.vector_out[gi] = r_out_data[MEM_WIDTH-1-gi*DATA_WIDTH -: DATA_WIDTH];
    end

    assign dump.out_valid = r_out_valid;
    assign dump.out_last  = r_out_last;
    assign fill_count     = r_fill;
    assign wrapped        = r_wrapped;
    assign frozen         = r_frozen;

    assign w_pop = r_out_valid & dump.out_ready;
    // Reads in flight plus held beats never exceed the two output slots.
    assign w_occ = {1'b0, r_out_valid} + {1'b0, r_skid_vld} + {1'b0, r_rd_vld};
    assign w_rd_issue = (r_state == DUMP) && (r_rd_left != '0) &&
                        ((w_occ - {1'b0, w_pop}) < 2'd2);

    always_comb begin
        w_state_nxt = r_state;
        w_wr        = tracing & valid_in & ((r_state == ARMED) || (r_state == POST));
        case (r_state)
            IDLE:   if (tracing) w_state_nxt = ARMED;
            ARMED: begin
                if (!tracing)        w_state_nxt = FROZEN;
                else if (trigger_in) w_state_nxt = (post_trig == '0) ? FROZEN : POST;
            end
            POST: begin
                if (!tracing)                          w_state_nxt = FROZEN;
                else if (w_wr && (r_post_cnt == C_ONE)) w_state_nxt = FROZEN;
            end
            FROZEN: if (dump_start) w_state_nxt = (r_fill != '0) ? DUMP : IDLE;
            DUMP:   if (w_pop && r_out_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_frozen   <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_post_cnt <= '0;
            r_rd_left  <= '0;
            r_wrapped  <= 1'b0;
            r_rd_vld   <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_frozen <= (w_state_nxt == FROZEN);
            r_rd_vld  <= w_rd_issue;
            r_rd_last <= w_rd_issue && (r_rd_left == C_ONE);

            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + C_PINC;
                if (r_fill == C_FULL) r_wrapped <= 1'b1;
                else                  r_fill    <= r_fill + C_ONE;
            end

            if ((r_state == ARMED) && trigger_in)  r_post_cnt <= post_trig;
            else if ((r_state == POST) && w_wr)    r_post_cnt <= r_post_cnt - C_ONE;

            if ((r_state == FROZEN) && dump_start) begin
                r_rd_ptr  <= r_wrapped ? r_wr_ptr : '0;
                r_rd_left <= r_fill;
            end else if (w_rd_issue) begin
                r_rd_ptr  <= r_rd_ptr + C_PINC;
                r_rd_left <= r_rd_left - C_ONE;
            end

            if ((r_state == DUMP) && (w_state_nxt == IDLE)) begin
                r_wr_ptr  <= '0;
                r_fill    <= '0;
                r_wrapped <= 1'b0;
            end
        end
    end

    // Output register backed by one skid slot for the read that was in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_skid_data <= '0;
            r_skid_vld  <= 1'b0;
            r_skid_last <= 1'b0;
        end else if (!r_out_valid || w_pop) begin
            if (r_skid_vld) begin
                r_out_data  <= r_skid_data;
                r_out_last  <= r_skid_last;
                r_out_valid <= 1'b1;
                r_skid_vld  <= r_rd_vld;
                r_skid_data <= w_rdata;
                r_skid_last <= r_rd_last;
            end else if (r_rd_vld) begin
                r_out_data  <= w_rdata;
                r_out_last  <= r_rd_last;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end else if (r_rd_vld) begin
            r_skid_data <= w_rdata;
            r_skid_last <= r_rd_last;
            r_skid_vld  <= 1'b1;
        end
    end

    ram_dual_port #(
        .WIDTH (MEM_WIDTH),
        .DEPTH (TB_SIZE)
    ) u_ram (
        .clk       (clk),
        .i_a_we    (w_wr),
        .i_a_addr  (r_wr_ptr),
        .i_a_wdata (w_wdata),
        .i_b_re    (w_rd_issue),
        .i_b_addr  (r_rd_ptr),
        .o_b_rdata (w_rdata)
    );
endmodule
`default_nettype wire

// File: tb/tb_trigger_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_trigger_trace_buffer
// Description : Scoreboard bench for trigger_trace_buffer (N=2, 8b, depth 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trigger_trace_buffer;
    localparam int N  = 2;
    localparam int DW = 8;
    localparam int SZ = 8;

    logic          clk = 1'b0;
    logic          rst_n, tracing, valid_in, trigger_in, dump_start;
    logic [DW-1:0] vin [N];
    logic [3:0]    post_trig;
    logic [3:0]    fill_count;
    logic          wrapped, frozen;

    always #5 clk = ~clk;

    trigger_trace_buffer_if #(.N(N), .DATA_WIDTH(DW)) dif ();

    trigger_trace_buffer #(.N(N), .DATA_WIDTH(DW), .TB_SIZE(SZ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tracing    (tracing),
        .valid_in   (valid_in),
        .vector_in  (vin),
        .trigger_in (trigger_in),
        .post_trig  (post_trig),
        .dump_start (dump_start),
        .dump       (dif),
        .fill_count (fill_count),
        .wrapped    (wrapped),
        .frozen     (frozen)
    );

    typedef struct packed {
        logic [7:0] l0;
        logic [7:0] l1;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    n_acc = 0;
    bit    pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted beat and checks holds.
    logic       prev_stall = 1'b0;
    logic [7:0] prev0, prev1;
    logic       prev_last;
    always @(negedge clk) begin
        if (prev_stall) begin
            check("hold_valid", dif.out_valid, 1);
            check("hold_lane0", dif.vector_out[0], prev0);
            check("hold_lane1", dif.vector_out[1], prev1);
            check("hold_last", dif.out_last, prev_last);
        end
        if (rst_n && dif.out_valid && dif.out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_beat: got lane0 %0h with no beat expected", dif.vector_out[0]);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("beat_lane0", dif.vector_out[0], e.l0);
                check("beat_lane1", dif.vector_out[1], e.l1);
                check("beat_last", dif.out_last, e.last);
            end
            n_acc++;
        end
        prev_stall = rst_n & dif.out_valid & ~dif.out_ready;
        prev0      = dif.vector_out[0];
        prev1      = dif.vector_out[1];
        prev_last  = dif.out_last;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] v);
        valid_in = 1'b1;
        vin[0]   = v;
        vin[1]   = v ^ 8'h5A;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic expect_range(input int lo, input int hi);
        for (int v = lo; v <= hi; v++) begin
            beat_t e;
            e.l0   = 8'(v);
            e.l1   = 8'(v) ^ 8'h5A;
            e.last = (v == hi);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_dump(input bit bp, output int lat, output int vcyc);
        int k;
        lat  = -1;
        vcyc = 0;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        k = 0;
        while (k < 200) begin
            if (dif.out_valid && lat < 0) lat = k;
            if (dif.out_valid) vcyc++;
            if (exp_q.size() == 0 && !dif.out_valid) break;
            dif.out_ready = bp ? pat[k % 6] : 1'b1;
            tick();
            k++;
        end
        dif.out_ready = 1'b1;
        if (k >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL dump_timeout: got %0d beats pending required 0", exp_q.size());
        end
        check("dump_drained", exp_q.size(), 0);
        check("post_dump_fill", fill_count, 0);
        check("post_dump_wrapped", wrapped, 0);
        check("post_dump_frozen", frozen, 0);
    endtask

    initial begin
        int lat, vc, base, k;
        rst_n = 1'b0; tracing = 1'b0; valid_in = 1'b0; trigger_in = 1'b0;
        dump_start = 1'b0; post_trig = 4'd0; vin[0] = '0; vin[1] = '0;
        dif.out_ready = 1'b1;
        tick(); tick();
        check("rst_out_valid", dif.out_valid, 0);
        check("rst_out_last", dif.out_last, 0);
        check("rst_frozen", frozen, 0);
        check("rst_fill", fill_count, 0);
        check("rst_wrapped", wrapped, 0);
        check("rst_vector", {dif.vector_out[0], dif.vector_out[1]}, 0);
        rst_n = 1'b1;
        tick();

        // Basic record and dump
        tracing = 1'b1; tick();
        for (int v = 1; v <= 5; v++) beat(8'(v));
        check("basic_fill", fill_count, 5);
        check("basic_wrapped", wrapped, 0);
        tracing = 1'b0; tick();
        check("basic_frozen", frozen, 1);
        expect_range(1, 5);
        do_dump(1'b0, lat, vc);
        check("basic_latency", 32'(lat), 2);
        check("basic_consecutive", 32'(vc), 5);

        // Wrap
        tracing = 1'b1; tick();
        for (int v = 1; v <= 11; v++) beat(8'(v));
        check("wrap_fill", fill_count, 8);
        check("wrap_wrapped", wrapped, 1);
        tracing = 1'b0; tick();
        expect_range(4, 11);
        do_dump(1'b0, lat, vc);

        // Post-trigger capture, with dump_start in ARMED and trigger in POST ignored
        tracing = 1'b1; tick();
        for (int v = 1; v <= 3; v++) beat(8'(v));
        dump_start = 1'b1; beat(8'd4); dump_start = 1'b0;
        check("armed_dump_frozen", frozen, 0);
        beat(8'd5);
        check("armed_dump_no_valid", dif.out_valid, 0);
        check("armed_dump_fill", fill_count, 5);
        post_trig = 4'd3; trigger_in = 1'b1;
        beat(8'd6);
        for (int v = 7; v <= 20; v++) begin
            trigger_in = (v == 7);
            beat(8'(v));
            if (v == 8) check("post_frozen_b8", frozen, 0);
            if (v == 9) check("post_frozen_b9", frozen, 1);
        end
        trigger_in = 1'b0;
        check("post_fill", fill_count, 8);
        check("post_wrapped", wrapped, 1);
        tracing = 1'b0; tick();
        expect_range(2, 9);
        do_dump(1'b0, lat, vc);

        // Dump with empty buffer
        tracing = 1'b1; tick();
        tracing = 1'b0; tick();
        check("empty_frozen", frozen, 1);
        check("empty_fill", fill_count, 0);
        dump_start = 1'b1; tick(); dump_start = 1'b0;
        check("empty_unfrozen", frozen, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("empty_no_valid", dif.out_valid, 0);
        end

        // post_trig = 0 freezes on the trigger edge
        tracing = 1'b1; tick();
        beat(8'd1); beat(8'd2);
        post_trig = 4'd0; trigger_in = 1'b1;
        beat(8'd3);
        trigger_in = 1'b0;
        check("pt0_frozen", frozen, 1);
        check("pt0_fill", fill_count, 3);
        beat(8'd4);
        check("pt0_no_write", fill_count, 3);
        tracing = 1'b0; tick();
        expect_range(1, 3);
        do_dump(1'b0, lat, vc);

        // Backpressure
        tracing = 1'b1; tick();
        for (int v = 1; v <= 6; v++) beat(8'(v + 16));
        tracing = 1'b0; tick();
        expect_range(17, 22);
        do_dump(1'b1, lat, vc);

        // Reset mid-dump
        tracing = 1'b1; tick();
        for (int v = 1; v <= 10; v++) beat(8'(v));
        tracing = 1'b0; tick();
        check("rstdump_wrapped_pre", wrapped, 1);
        expect_range(3, 4);
        exp_q[1].last = 1'b0;
        base = n_acc;
        dump_start = 1'b1; tick(); dump_start = 1'b0;
        k = 0;
        while ((n_acc - base) < 2 && k < 20) begin
            tick();
            k++;
        end
        if (k >= 20) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rstdump_timeout: got %0d accepted required 2", n_acc - base);
        end
        dif.out_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        check("rstdump_out_valid", dif.out_valid, 0);
        check("rstdump_out_last", dif.out_last, 0);
        check("rstdump_fill", fill_count, 0);
        check("rstdump_wrapped", wrapped, 0);
        check("rstdump_frozen", frozen, 0);
        check("rstdump_queue", exp_q.size(), 0);
        rst_n = 1'b1;
        dif.out_ready = 1'b1;
        tracing = 1'b1;
        beat(8'hAA);
        check("rstdump_idle_no_write", fill_count, 0);
        tracing = 1'b1;
        beat(8'hAB);
        check("rstdump_armed_write", fill_count, 1);
        tracing = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/trigger_trace_buffer.md
# trigger_trace_buffer

Parametrised circular trace buffer with trigger-and-freeze capture and a handshaked, oldest-first readout port. Sits at the tail of the debug datapath, where it records N-lane vectors while tracing. After a trigger it captures a programmable number of post-trigger beats, then freezes so the host can drain the history in order without losing data.

## Interface
- N, 8, lanes per vector
- DATA_WIDTH, 32, bits per lane
- TB_SIZE, 64, entries; power of two, >= 4
- AW (localparam), $clog2(TB_SIZE), address width
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- tracing  in  1  recording enable
- valid_in  in  1  vector_in beat valid
- vector_in  in  [DATA_WIDTH-1:0] x N  input vector
- trigger_in  in  1  trigger event
- post_trig  in  AW+1  post-trigger beat count; sampled on the trigger cycle
- dump_start  in  1  begin readout; honoured only in FROZEN
- vector_out  out  [DATA_WIDTH-1:0] x N  readout vector
- out_valid  out  1  vector_out valid
- out_ready  in  1  consumer accepts beat
- out_last  out  1  qualifies the final beat of a dump
- fill_count  out  AW+1  stored entries, saturating at TB_SIZE
- wrapped  out  1  sticky: buffer overwrote its oldest entry
- frozen  out  1  high in FROZEN

## Operation
- Write condition: `wr = tracing & valid_in & state in {ARMED, POST}`.
  - On a write, store at wr_ptr, then `wr_ptr = wr_ptr+1 mod TB_SIZE`.
  - fill_count increments on each write and saturates at TB_SIZE.
  - wrapped sets on a write when fill_count == TB_SIZE.
- States and transitions:
  - IDLE: no writes. tracing=1 -> ARMED.
  - ARMED: records. trigger_in=1 -> POST with `post_cnt = post_trig`.
    - If post_trig == 0, go directly to FROZEN.
    - The trigger-cycle beat is written if wr=1 and does not count toward post_cnt.
  - POST: records. post_cnt decrements on each write; the write that reaches 0 -> FROZEN. trigger_in is ignored.
  - ARMED/POST with tracing=0: manual stop -> FROZEN.
  - FROZEN: no writes.
    - dump_start with fill_count > 0 -> DUMP.
    - dump_start with fill_count == 0 -> IDLE, and no beats are emitted.
  - DUMP: reads fill_count entries, oldest first, starting at `rd_ptr = wrapped ? wr_ptr : 0`.
    - After the beat with out_last is accepted: go to IDLE, clear wr_ptr, fill_count and wrapped.
- dump_start is ignored outside FROZEN. trigger_in is ignored outside ARMED.
- On reset, asserted in any state including mid-dump:
  - State goes to IDLE.
  - Pointers, counts and wrapped clear.
  - out_valid and out_last go low; the skid buffer empties.
  - RAM contents are not cleared.

## Timing
- Reset values: out_valid=0, out_last=0, frozen=0, fill_count=0, wrapped=0, vector_out=0.
- All outputs are registered.
- RAM read latency is 1 cycle.
- Dump start latency: dump_start sampled at edge k -> first read issued in cycle k+1 -> out_valid high after edge k+2.
- Output throughput is 1 beat/cycle while out_ready=1.
  - A 2-entry skid buffer absorbs reads already in flight, so deasserting out_ready never drops or duplicates a beat.
  - vector_out/out_last must hold while out_valid=1 and out_ready=0.
- frozen rises the cycle after the FROZEN transition edge, and falls the cycle after DUMP/IDLE entry.
- A write takes effect at the edge where wr=1. fill_count reflects the write the next cycle.

## Structure
- Package trace_buffer_pkg:
  - tb_state_t enum {IDLE, ARMED, POST, FROZEN, DUMP}
  - localparam helpers for AW and MEM_WIDTH = N*DATA_WIDTH
- Sub-module ram_dual_port, 1-cycle latency:
  - Port A is write-only.
  - Port B is read-only.
  - Width is MEM_WIDTH, depth is TB_SIZE.
- Lane packing is MSB-first: lane 0 occupies the top DATA_WIDTH bits.
- The FSM, pointers and skid buffer live in the top module.

## Test plan
All scenarios use N=2, DATA_WIDTH=8, TB_SIZE=8.
- Basic record and dump:
  - Stimulus: tracing=1; write 5 beats with lane0 = 1..5; tracing=0; dump with out_ready=1.
  - Required: out_valid first seen 2 cycles after dump_start; beats 1..5 on consecutive cycles; out_last on 5; fill_count returns to 0.
- Wrap:
  - Stimulus: 11 beats, values 1..11; stop; dump.
  - Required: wrapped=1, fill_count=8; beats 4..11 oldest-first; out_last on 11.
- Post-trigger capture:
  - Stimulus: post_trig=3; trigger_in asserted with beat 6 in ARMED; keep writing 7..20.
  - Required: FROZEN after beat 9; dump yields 2..9.
- Backpressure:
  - Stimulus: during a dump, toggle out_ready as 1,0,0,1,0,1...
  - Required: every value emitted exactly once and in order; vector_out stable while stalled.
- Edge cases:
  - post_trig=0 -> freeze on the trigger edge.
  - dump_start in ARMED -> ignored.
  - dump_start with fill_count 0 -> IDLE, out_valid never rises.
- Reset mid-dump:
  - Stimulus: rst_n=0 after 2 accepted beats.
  - Required: out_valid=0 on the next cycle; state IDLE; fill_count=0; wrapped=0.
